tree_image_loader: RTL and testbench
====================================

// Module: tree_image_loader
// PURPOSE
//  Upstream stage of the BDD traversal engine. Accepts a byte-serial tree image over a valid/ready stream.
//  Assembles node-threshold words (RAM1) and child-pointer words (RAM2) from that stream.
//  Drives the engine's we1/we2/in_addr/ram1_data_in/ram2_data_in write port.
//  Holds the engine in reset while an image is loading or after a failed load.
// PARAMETERS
//  RAM1_DATA_WIDTH  34  threshold word width; one word = 5 stream bytes
//  RAM2_DATA_WIDTH  16  child word width; one word = 2 stream bytes
//  ADDR_WIDTH       4   node address width
//  DEPTH            16  max nodes; must equal 2**ADDR_WIDTH
//  WE_HOLD          4   cycles each write strobe is held (engine RAMs run on clk/4, clk/2)
// PORTS
//  clk          in   1                clock
//  rst_n        in   1                synchronous active-low reset
//  s_data       in   8                image byte
//  s_valid      in   1                s_data valid
//  s_ready      out  1                byte accepted when s_valid&&s_ready at posedge clk
//  we1          out  1                RAM1 write strobe
//  we2          out  1                RAM2 write strobe
//  addr         out  ADDR_WIDTH       node address for both RAMs
//  ram1_data    out  RAM1_DATA_WIDTH  threshold word
//  ram2_data    out  RAM2_DATA_WIDTH  child word
//  busy         out  1                image load in progress
//  load_done    out  1                1-cycle pulse: image accepted, checksum good
//  load_err     out  1                sticky: last load failed
//  eng_rst_n    out  1                engine reset; low while busy or load_err
// BEHAVIOUR
//  Reset: state IDLE; s_ready=1; we1=we2=busy=load_done=load_err=0; addr/data=0; eng_rst_n=0 until first good load.
//  Frame: 0xA5, N, then N x {5 RAM1 bytes, 2 RAM2 bytes}, then CHK. All fields big-endian.
//   First RAM1 byte bits[1:0] -> data[33:32]; its bits[7:2] are ignored.
//   CHK = XOR of N and all node bytes.
//  FSM:
//   IDLE: byte!=0xA5 discarded. 0xA5 -> CNT; clears load_err; busy=1.
//   CNT: N==0 or N>DEPTH -> ERR. Otherwise store N, addr=0 -> R1.
//   R1: shift 5 bytes into ram1_data -> WR1.
//   WR1: we1=1 for WE_HOLD cycles; s_ready=0; addr/data stable -> R2.
//   R2: shift 2 bytes into ram2_data -> WR2.
//   WR2: we2=1 for WE_HOLD cycles; s_ready=0.
//    If addr==N-1 -> CHK; else addr+1 -> R1.
//   CHK: byte==running XOR -> DONE; else -> ERR.
//   DONE: load_done=1 for one cycle; busy=0; eng_rst_n=1 from the next cycle -> IDLE.
//   ERR: load_err=1; busy=0 -> IDLE.
//  s_ready=1 in IDLE/CNT/R1/R2/CHK; 0 in WR1/WR2/DONE/ERR.
//  s_valid gaps stall the shift counters with no state change.
//  The running XOR resets on 0xA5 acceptance.
//  On error, RAM may hold a partial image; eng_rst_n stays low until the next good load.
//  addr never exceeds DEPTH-1; no wrap.
//  rst_n low mid-load: immediate return to reset values; partial image is abandoned.
// STRUCTURE
//  Shared package bdd_pkg: SYNC_BYTE=8'hA5, loader state enum, RAM widths.
//  One natural sub-module: byte_packer (parameterised shift-assemble of K bytes into a W-bit word).
//   Instantiated twice: K=5/W=34 and K=2/W=16.
//  Strobe hold uses one shared down-counter.
// TESTING
//  1. 1-node image: A5 01 03 00 00 00 10 81 23 CHK.
//     -> we1 held 4 cycles, addr=0, ram1_data=34'h3_0000_0010.
//     -> we2 held 4 cycles, ram2_data=16'h8123.
//     -> load_done pulse; eng_rst_n=1.
//  2. Full DEPTH=16 image with random s_valid gaps (~30%).
//     -> 16 we1 and 16 we2 strobes at addr 0..15; load_done; no byte lost.
//  3. Good frame with CHK xor 8'h01 -> load_err=1, eng_rst_n=0, no load_done.
//     -> next good frame clears load_err and sets eng_rst_n=1.
//  4. A5 00 -> ERR with no we strobes. A5 11 (N=17) -> ERR with no we strobes.
//  5. Leading junk 00 FF 5A before A5 -> discarded; the frame then loads normally.
//  6. rst_n low for 1 cycle after the 3rd RAM1 byte of node 2.
//     -> all outputs return to reset values; a fresh full frame then loads correctly.

Source files
------------

// File: rtl/bdd_pkg.sv
// Shared definitions for the BDD traversal engine front end.
// Holds the tree-image sync byte, the default RAM geometry and the state type
// of the tree image loader.
package bdd_pkg;

  localparam int RAM1_DATA_WIDTH = 34;
  localparam int RAM2_DATA_WIDTH = 16;
  localparam int ADDR_WIDTH      = 4;
  localparam int DEPTH           = 16;
  localparam int WE_HOLD         = 4;

  // Stream bytes that make up one threshold word and one child word
  localparam int RAM1_BYTES = 5;
  localparam int RAM2_BYTES = 2;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CNT,
    ST_R1,
    ST_WR1,
    ST_R2,
    ST_WR2,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// Shift-assembles K stream bytes, big-endian, into a W-bit word.
// Bits of the first byte that do not fit into W are dropped.
// Ports:
//   clk      in  clock
//   rst_n    in  synchronous active-low reset (clears word and byte count)
//   shift_en in  shift byte_in into the word this cycle
//   byte_in  in  8-bit stream byte
//   word     out assembled word (registered, holds between shifts)
//   last     out the next shift completes the word
module byte_packer #(
  parameter int K = 5,
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic [7:0]   byte_in,
  output logic [W-1:0] word,
  output logic         last
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(K - 1);

  logic [W-1:0]  word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign word = word_q;
  assign last = (cnt_q == LAST_CNT);

  // The byte counter wraps after the K-th byte so the next word starts clean
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (shift_en) begin
      word_d = {word_q[W-9:0], byte_in};
      cnt_d  = last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/tree_image_loader.sv
// Tree image loader: receives a byte-serial BDD tree image over a valid/ready
// stream and writes threshold words (RAM1) and child words (RAM2) into the
// traversal engine, holding the engine in reset until an image loads cleanly.
// Frame: A5, N, N x {5 RAM1 bytes, 2 RAM2 bytes}, CHK (XOR of N and node bytes).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   s_data/s_valid      incoming image byte stream
//   s_ready             byte accepted when s_valid && s_ready at posedge clk
//   we1, we2            RAM1/RAM2 write strobes, each held WE_HOLD cycles
//   addr                node address shared by both RAMs
//   ram1_data/ram2_data write data for RAM1/RAM2
//   busy                image load in progress
//   load_done           one-cycle pulse on a load with good checksum
//   load_err            sticky flag: the last load failed
//   eng_rst_n           engine reset, released only after a good load
module tree_image_loader
  import bdd_pkg::*;
#(
  parameter int RAM1_DATA_WIDTH = bdd_pkg::RAM1_DATA_WIDTH,
  parameter int RAM2_DATA_WIDTH = bdd_pkg::RAM2_DATA_WIDTH,
  parameter int ADDR_WIDTH      = bdd_pkg::ADDR_WIDTH,
  parameter int DEPTH           = bdd_pkg::DEPTH,
  parameter int WE_HOLD         = bdd_pkg::WE_HOLD
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic                       we1,
  output logic                       we2,
  output logic [ADDR_WIDTH-1:0]      addr,
  output logic [RAM1_DATA_WIDTH-1:0] ram1_data,
  output logic [RAM2_DATA_WIDTH-1:0] ram2_data,
  output logic                       busy,
  output logic                       load_done,
  output logic                       load_err,
  output logic                       eng_rst_n
);

  localparam int HOLD_W = (WE_HOLD > 1) ? $clog2(WE_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(WE_HOLD - 1);

  loader_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     n_q, n_d;
  logic [7:0]              xor_q, xor_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic                    we1_q, we1_d;
  logic                    we2_q, we2_d;
  logic                    s_ready_q, s_ready_d;
  logic                    busy_q, busy_d;
  logic                    load_done_q, load_done_d;
  logic                    load_err_q, load_err_d;
  logic                    eng_rst_n_q, eng_rst_n_d;

  logic accept;
  logic shift1, shift2;
  logic last1, last2;
  logic bad_count;
  logic last_node;

  assign accept    = s_valid && s_ready_q;
  assign shift1    = accept && (state_q == ST_R1);
  assign shift2    = accept && (state_q == ST_R2);
  assign bad_count = (s_data == 8'd0) || (int'(s_data) > DEPTH);
  assign last_node = ({1'b0, addr_q} == (n_q - (ADDR_WIDTH+1)'(1)));

  byte_packer #(.K(RAM1_BYTES), .W(RAM1_DATA_WIDTH)) u_pack1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift1),
    .byte_in  (s_data),
    .word     (ram1_data),
    .last     (last1)
  );

  byte_packer #(.K(RAM2_BYTES), .W(RAM2_DATA_WIDTH)) u_pack2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift2),
    .byte_in  (s_data),
    .word     (ram2_data),
    .last     (last2)
  );

  // Next-state logic. The write strobes reuse one down-counter, loaded on
  // entry to WR1/WR2; the strobe drops on the cycle the counter reads zero.
  // s_ready is derived from the next state so it is registered with it.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    n_d         = n_q;
    xor_d       = xor_q;
    hold_d      = hold_q;
    we1_d       = we1_q;
    we2_d       = we2_q;
    busy_d      = busy_q;
    load_done_d = 1'b0;
    load_err_d  = load_err_q;
    eng_rst_n_d = eng_rst_n_q;

    case (state_q)
      ST_IDLE: begin
        if (accept && (s_data == SYNC_BYTE)) begin
          state_d     = ST_CNT;
          load_err_d  = 1'b0;
          busy_d      = 1'b1;
          eng_rst_n_d = 1'b0;
          xor_d       = 8'd0;
        end
      end
      ST_CNT: begin
        if (accept) begin
          xor_d = xor_q ^ s_data;
          if (bad_count) begin
            state_d    = ST_ERR;
            load_err_d = 1'b1;
            busy_d     = 1'b0;
          end else begin
            n_d     = s_data[ADDR_WIDTH:0];
            addr_d  = '0;
            state_d = ST_R1;
          end
        end
      end
      ST_R1: begin
        if (accept) begin
          xor_d = xor_q ^ s_data;
          if (last1) begin
            state_d = ST_WR1;
            we1_d   = 1'b1;
            hold_d  = HOLD_INIT;
          end
        end
      end
      ST_WR1: begin
        if (hold_q == '0) begin
          we1_d   = 1'b0;
          state_d = ST_R2;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      ST_R2: begin
        if (accept) begin
          xor_d = xor_q ^ s_data;
          if (last2) begin
            state_d = ST_WR2;
            we2_d   = 1'b1;
            hold_d  = HOLD_INIT;
          end
        end
      end
      ST_WR2: begin
        if (hold_q == '0) begin
          we2_d = 1'b0;
          if (last_node) begin
            state_d = ST_CHK;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = ST_R1;
          end
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      ST_CHK: begin
        if (accept) begin
          busy_d = 1'b0;
          if (s_data == xor_q) begin
            state_d     = ST_DONE;
            load_done_d = 1'b1;
          end else begin
            state_d    = ST_ERR;
            load_err_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        eng_rst_n_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_IDLE, ST_CNT, ST_R1, ST_R2, ST_CHK: s_ready_d = 1'b1;
      default:                               s_ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      n_q         <= '0;
      xor_q       <= '0;
      hold_q      <= '0;
      we1_q       <= 1'b0;
      we2_q       <= 1'b0;
      s_ready_q   <= 1'b1;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      eng_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      n_q         <= n_d;
      xor_q       <= xor_d;
      hold_q      <= hold_d;
      we1_q       <= we1_d;
      we2_q       <= we2_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      eng_rst_n_q <= eng_rst_n_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign we1       = we1_q;
  assign we2       = we2_q;
  assign addr      = addr_q;
  assign busy      = busy_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;
  assign eng_rst_n = eng_rst_n_q;

endmodule

// File: tb/tb_tree_image_loader.sv
// Bench for tree_image_loader. A frame-level model pushes the writes each
// node must produce; a negedge monitor checks every strobe cycle against it.
module tb_tree_image_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        we1;
  logic        we2;
  logic [3:0]  addr;
  logic [33:0] ram1_data;
  logic [15:0] ram2_data;
  logic        busy;
  logic        load_done;
  logic        load_err;
  logic        eng_rst_n;

  tree_image_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .we1       (we1),
    .we2       (we2),
    .addr      (addr),
    .ram1_data (ram1_data),
    .ram2_data (ram2_data),
    .busy      (busy),
    .load_done (load_done),
    .load_err  (load_err),
    .eng_rst_n (eng_rst_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  a;
    logic [33:0] d;
  } w1_t;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } w2_t;

  w1_t exp1q[$];
  w2_t exp2q[$];
  w1_t cur1;
  w2_t cur2;

  int compared   = 0;
  int mismatched = 0;
  int we1Count   = 0;
  int we2Count   = 0;
  int doneCount  = 0;
  int run1       = 0;
  int run2       = 0;
  int doneRun    = 0;
  logic [33:0] last1Data;
  logic [15:0] last2Data;

  logic [7:0] nodeBytes [16][7];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Strobe monitor: every cycle a strobe is high, address and data must match
  // the node the model expects next, and the stream must be stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      run1    = 0;
      run2    = 0;
      doneRun = 0;
    end else begin
      if (we1) begin
        if (run1 == 0) begin
          if (exp1q.size() == 0) checkOutput("we1Unexpected", 64'(1), 64'(0));
          else cur1 = exp1q.pop_front();
          we1Count++;
        end
        run1++;
        checkOutput("we1Addr", 64'(addr), 64'(cur1.a));
        checkOutput("we1Data", 64'(ram1_data), 64'(cur1.d));
        checkOutput("we1Ready", 64'(s_ready), 64'(0));
        last1Data = ram1_data;
      end else if (run1 != 0) begin
        checkOutput("we1Hold", 64'(run1), 64'(4));
        run1 = 0;
      end
      if (we2) begin
        if (run2 == 0) begin
          if (exp2q.size() == 0) checkOutput("we2Unexpected", 64'(1), 64'(0));
          else cur2 = exp2q.pop_front();
          we2Count++;
        end
        run2++;
        checkOutput("we2Addr", 64'(addr), 64'(cur2.a));
        checkOutput("we2Data", 64'(ram2_data), 64'(cur2.d));
        checkOutput("we2Ready", 64'(s_ready), 64'(0));
        last2Data = ram2_data;
      end else if (run2 != 0) begin
        checkOutput("we2Hold", 64'(run2), 64'(4));
        run2 = 0;
      end
      if (load_done) begin
        if (doneRun == 0) doneCount++;
        doneRun++;
      end else if (doneRun != 0) begin
        checkOutput("doneWidth", 64'(doneRun), 64'(1));
        doneRun = 0;
      end
    end
  end

  // Offers one byte from a negedge and returns on the negedge after the
  // accepting posedge; s_ready only moves at posedge so negedge sampling is safe.
  task automatic sendByte(input logic [7:0] b, input bit gaps);
    int budget;
    while (gaps && ($urandom_range(0, 9) < 3)) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = b;
    budget  = 0;
    while (!s_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!s_ready) checkOutput("handshakeTimeout", 64'(0), 64'(1));
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic checkReset();
    checkOutput("rstReady", 64'(s_ready), 64'(1));
    checkOutput("rstWe1", 64'(we1), 64'(0));
    checkOutput("rstWe2", 64'(we2), 64'(0));
    checkOutput("rstAddr", 64'(addr), 64'(0));
    checkOutput("rstRam1", 64'(ram1_data), 64'(0));
    checkOutput("rstRam2", 64'(ram2_data), 64'(0));
    checkOutput("rstBusy", 64'(busy), 64'(0));
    checkOutput("rstDone", 64'(load_done), 64'(0));
    checkOutput("rstErr", 64'(load_err), 64'(0));
    checkOutput("rstEng", 64'(eng_rst_n), 64'(0));
  endtask

  task automatic pulseReset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    checkReset();
    rst_n = 1'b1;
  endtask

  task automatic fillNodes(input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 7; j++)
        nodeBytes[i][j] = 8'($urandom_range(0, 255));
  endtask

  // Sends a whole frame built from nodeBytes, queueing the expected writes.
  // abortNode/abortIdx select a byte after which reset is pulsed instead.
  task automatic applyStimulus(input int n, input bit badChk, input bit gaps,
                               input int abortNode, input int abortIdx);
    logic [7:0] chk;
    w1_t e1;
    w2_t e2;
    chk = n[7:0];
    sendByte(8'hA5, gaps);
    sendByte(n[7:0], gaps);
    for (int i = 0; i < n; i++) begin
      e1.a = 4'(i);
      e1.d = {nodeBytes[i][0][1:0], nodeBytes[i][1], nodeBytes[i][2],
              nodeBytes[i][3], nodeBytes[i][4]};
      e2.a = 4'(i);
      e2.d = {nodeBytes[i][5], nodeBytes[i][6]};
      exp1q.push_back(e1);
      exp2q.push_back(e2);
      for (int j = 0; j < 7; j++) begin
        chk = chk ^ nodeBytes[i][j];
        sendByte(nodeBytes[i][j], gaps);
        if (i == abortNode && j == abortIdx) begin
          pulseReset();
          return;
        end
      end
    end
    sendByte(badChk ? (chk ^ 8'h01) : chk, gaps);
  endtask

  task automatic frameEnd(input bit expectDone);
    int t;
    t = 0;
    while (!(load_done || load_err) && t < 40) begin
      @(negedge clk);
      t++;
    end
    checkOutput("frameEndSeen", 64'(load_done || load_err), 64'(1));
    checkOutput("frameDone", 64'(load_done), 64'(expectDone));
    checkOutput("frameErr", 64'(load_err), 64'(!expectDone));
    checkOutput("frameBusy", 64'(busy), 64'(0));
    checkOutput("frameEngEarly", 64'(eng_rst_n), 64'(0));
    @(negedge clk);
    checkOutput("frameEng", 64'(eng_rst_n), 64'(expectDone));
    checkOutput("frameDoneClr", 64'(load_done), 64'(0));
    checkOutput("frameErrSticky", 64'(load_err), 64'(!expectDone));
    checkOutput("frameExp1Empty", 64'(exp1q.size()), 64'(0));
    checkOutput("frameExp2Empty", 64'(exp2q.size()), 64'(0));
  endtask

  initial begin
    w1_t e1;
    w2_t e2;
    int  w1Before;
    int  w2Before;
    int  dBefore;

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkReset();
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: literal one-node image, expected words written out by hand
    $display("[TB] test 1: single node");
    e1.a = 4'd0;
    e1.d = 34'h3_0000_0010;
    e2.a = 4'd0;
    e2.d = 16'h8123;
    exp1q.push_back(e1);
    exp2q.push_back(e2);
    w1Before = we1Count;
    w2Before = we2Count;
    sendByte(8'hA5, 1'b0);
    checkOutput("t1Busy", 64'(busy), 64'(1));
    sendByte(8'h01, 1'b0);
    sendByte(8'h03, 1'b0);
    sendByte(8'h00, 1'b0);
    sendByte(8'h00, 1'b0);
    sendByte(8'h00, 1'b0);
    sendByte(8'h10, 1'b0);
    sendByte(8'h81, 1'b0);
    sendByte(8'h23, 1'b0);
    sendByte(8'hB0, 1'b0);
    frameEnd(1'b1);
    checkOutput("t1Ram1", 64'(last1Data), 64'h3_0000_0010);
    checkOutput("t1Ram2", 64'(last2Data), 64'h8123);
    checkOutput("t1We1Cnt", 64'(we1Count - w1Before), 64'(1));
    checkOutput("t1We2Cnt", 64'(we2Count - w2Before), 64'(1));

    // Test 2: full depth with stream gaps
    $display("[TB] test 2: 16 nodes with gaps");
    fillNodes(16);
    w1Before = we1Count;
    w2Before = we2Count;
    applyStimulus(16, 1'b0, 1'b1, -1, -1);
    frameEnd(1'b1);
    checkOutput("t2We1Cnt", 64'(we1Count - w1Before), 64'(16));
    checkOutput("t2We2Cnt", 64'(we2Count - w2Before), 64'(16));

    // Test 3: corrupted checksum, then recovery
    $display("[TB] test 3: bad checksum");
    fillNodes(3);
    dBefore = doneCount;
    applyStimulus(3, 1'b1, 1'b0, -1, -1);
    frameEnd(1'b0);
    checkOutput("t3NoDone", 64'(doneCount - dBefore), 64'(0));
    fillNodes(2);
    applyStimulus(2, 1'b0, 1'b0, -1, -1);
    frameEnd(1'b1);

    // Test 4: illegal node counts
    $display("[TB] test 4: bad counts");
    w1Before = we1Count;
    w2Before = we2Count;
    sendByte(8'hA5, 1'b0);
    sendByte(8'h00, 1'b0);
    frameEnd(1'b0);
    sendByte(8'hA5, 1'b0);
    sendByte(8'h11, 1'b0);
    frameEnd(1'b0);
    repeat (3) @(negedge clk);
    checkOutput("t4We1Cnt", 64'(we1Count - w1Before), 64'(0));
    checkOutput("t4We2Cnt", 64'(we2Count - w2Before), 64'(0));

    // Test 5: junk ahead of the sync byte
    $display("[TB] test 5: leading junk");
    sendByte(8'h00, 1'b0);
    sendByte(8'hFF, 1'b0);
    sendByte(8'h5A, 1'b0);
    checkOutput("t5IdleBusy", 64'(busy), 64'(0));
    fillNodes(4);
    w1Before = we1Count;
    applyStimulus(4, 1'b0, 1'b0, -1, -1);
    frameEnd(1'b1);
    checkOutput("t5We1Cnt", 64'(we1Count - w1Before), 64'(4));

    // Test 6: reset in the middle of node 2, then a fresh full frame
    $display("[TB] test 6: mid-load reset");
    fillNodes(5);
    w1Before = we1Count;
    applyStimulus(5, 1'b0, 1'b0, 2, 2);
    checkOutput("t6We1Cnt", 64'(we1Count - w1Before), 64'(2));
    checkOutput("t6Pending", 64'(exp1q.size()), 64'(1));
    exp1q.delete();
    exp2q.delete();
    @(negedge clk);
    fillNodes(16);
    w1Before = we1Count;
    w2Before = we2Count;
    applyStimulus(16, 1'b0, 1'b1, -1, -1);
    frameEnd(1'b1);
    checkOutput("t6We1Full", 64'(we1Count - w1Before), 64'(16));
    checkOutput("t6We2Full", 64'(we2Count - w2Before), 64'(16));

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
